// File: rtl/hs_pkg.sv
// Shared constants, state encoding and helpers for the handshake scheduler.
// The state enum takes its values from the localparams so that the encoding is defined in one place.
package hs_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_TIMEOUT_CYC = 16;
    localparam int DEF_MAX_RETRY   = 3;

    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int TIMER_W = 8;
    localparam int RETRY_W = 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYN  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACK  = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        SYN  = ST_SYN,
        WAIT = ST_WAIT,
        ACK  = ST_ACK,
        FAIL = ST_FAIL
    } hs_state_e;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/handshake_scheduler_if.sv
// Requester/network handshake bundle between the scheduler (slave) and its environment (master).
interface handshake_scheduler_if
    import hs_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) ();

    logic [N_REQ-1:0] req;
    logic             rcv_syn_ack;
    logic [N_REQ-1:0] grant;
    logic             send_syn;
    logic             send_ack;
    logic [N_REQ-1:0] open_done;
    logic [N_REQ-1:0] open_fail;
    logic             busy;

    modport master (
        output req, rcv_syn_ack,
        input  grant, send_syn, send_ack, open_done, open_fail, busy
    );

    modport slave (
        input  req, rcv_syn_ack,
        output grant, send_syn, send_ack, open_done, open_fail, busy
    );

endinterface

// File: rtl/handshake_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit searching upward from last_owner+1, wrapping.
module rr_arbiter
    import hs_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] sel;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            sel = N_REQ'(1) << ((int'(last_owner) + off) % N_REQ);
            if (!found && ((req & sel) != '0)) begin
                grant = sel;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_scheduler.sv
// Single-channel SYN / SYN-ACK / ACK opener shared round-robin between N_REQ requesters,
// with per-SYN timeout and bounded retransmission.
module handshake_scheduler
    import hs_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                  clock,
    input  logic                  rst,
    handshake_scheduler_if.slave  hs
);

    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

    hs_state_e          state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]   owner_idx;
    logic               owner_req;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req        (hs.req),
        .last_owner (last_owner_q),
        .grant      (arb_grant)
    );

    assign owner_idx = onehot_to_idx(MAX_REQ'(grant_q));
    assign owner_req = (hs.req & grant_q) != '0;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            timer_q      <= '0;
            retry_q      <= '0;
            last_owner_q <= IDX_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            last_owner_q <= last_owner_d;
        end
    end

    // The timer is loaded on entry to SYN and the SYN cycle already counts down,
    // so consecutive SYN strobes are exactly TIMEOUT_CYC cycles apart.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        timer_d      = timer_q;
        retry_d      = retry_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (hs.req != '0) begin
                    grant_d = arb_grant;
                    retry_d = '0;
                    timer_d = TIMER_LOAD;
                    state_d = SYN;
                end
            end
            SYN: begin
                if (!owner_req) begin
                    grant_d      = '0;
                    last_owner_d = owner_idx;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!owner_req) begin
                    grant_d      = '0;
                    last_owner_d = owner_idx;
                    state_d      = IDLE;
                end else if (hs.rcv_syn_ack) begin
                    state_d = ACK;
                end else if (timer_q == '0) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = TIMER_LOAD;
                        state_d = SYN;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ACK, FAIL: begin
                grant_d      = '0;
                last_owner_d = owner_idx;
                state_d      = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign hs.grant     = grant_q;
    assign hs.send_syn  = (state_q == SYN);
    assign hs.send_ack  = (state_q == ACK);
    assign hs.open_done = (state_q == ACK)  ? grant_q : '0;
    assign hs.open_fail = (state_q == FAIL) ? grant_q : '0;
    assign hs.busy      = (state_q != IDLE);

endmodule
